// File: rtl/plic_gateway_arbiter.sv
// Interrupt gateway and priority arbiter: per-source level gateways with pending bits,
// priority/threshold arbitration to a single hart line, and claim/complete registers.
module plic_gateway_arbiter #(
  parameter int unsigned SRC_NUM = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] irq_src,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [5:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               irq_out
);

  localparam int unsigned IDW = $clog2(SRC_NUM + 1);

  typedef enum logic {
    GW_IDLE,
    GW_CLAIMED
  } gw_state_t;

  gw_state_t          r_gw      [1:SRC_NUM];
  gw_state_t          w_gw_next [1:SRC_NUM];
  logic [PRIO_W-1:0]  r_prio    [1:SRC_NUM];
  logic [SRC_NUM:1]   r_pending;
  logic [SRC_NUM:1]   w_pend_next;
  logic [SRC_NUM:1]   r_enable;
  logic [PRIO_W-1:0]  r_thresh;
  logic [IDW-1:0]     r_best_id;
  logic [IDW-1:0]     w_best_id;
  logic [PRIO_W-1:0]  w_best_prio;
  logic               r_irq;
  logic [31:0]        r_rdata;
  logic [31:0]        w_rdata;
  logic               w_rd;
  logic               w_claim;
  logic               w_complete;

  // A simultaneous write wins; the read is dropped entirely.
  assign w_rd       = reg_rd & ~reg_wr;
  assign w_claim    = w_rd && (reg_addr == 6'h23) && (r_best_id != '0);
  assign w_complete = reg_wr && (reg_addr == 6'h23);

  assign reg_rdata = r_rdata;
  assign irq_out   = r_irq;

  always_comb begin
    w_gw_next   = r_gw;
    w_pend_next = r_pending;
    for (int unsigned i = 1; i <= SRC_NUM; i++) begin
      unique case (r_gw[i])
        GW_IDLE: begin
          if (irq_src[i-1]) w_pend_next[i] = 1'b1;
          if (w_claim && (r_best_id == IDW'(i))) begin
            w_pend_next[i] = 1'b0;
            w_gw_next[i]   = GW_CLAIMED;
          end
        end
        GW_CLAIMED: begin
          w_pend_next[i] = 1'b0;
          if (w_complete && (reg_wdata == 32'(i))) w_gw_next[i] = GW_IDLE;
        end
        default: w_gw_next[i] = GW_IDLE;
      endcase
    end
  end

  // Ascending scan with strict '>' keeps the lowest ID on equal priority;
  // the source being claimed this edge is masked so the next winner is ready at once.
  always_comb begin
    w_best_id   = '0;
    w_best_prio = '0;
    for (int unsigned i = 1; i <= SRC_NUM; i++) begin
      if (r_pending[i] && r_enable[i] && (r_prio[i] > r_thresh) &&
          !(w_claim && (r_best_id == IDW'(i))) && (r_prio[i] > w_best_prio)) begin
        w_best_id   = IDW'(i);
        w_best_prio = r_prio[i];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 1; i <= SRC_NUM; i++) begin
      if (reg_addr == 6'(i)) w_rdata = 32'(r_prio[i]);
    end
    case (reg_addr)
      6'h20:   w_rdata = 32'({r_pending, 1'b0});
      6'h21:   w_rdata = 32'({r_enable, 1'b0});
      6'h22:   w_rdata = 32'(r_thresh);
      6'h23:   w_rdata = 32'(r_best_id);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i <= SRC_NUM; i++) r_gw[i] <= GW_IDLE;
    end else begin
      for (int unsigned i = 1; i <= SRC_NUM; i++) r_gw[i] <= w_gw_next[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i <= SRC_NUM; i++) r_prio[i] <= '0;
      r_pending <= '0;
      r_enable  <= '0;
      r_thresh  <= '0;
      r_best_id <= '0;
      r_irq     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      for (int unsigned i = 1; i <= SRC_NUM; i++) begin
        if (reg_wr && (reg_addr == 6'(i))) r_prio[i] <= reg_wdata[PRIO_W-1:0];
      end
      if (reg_wr && (reg_addr == 6'h21)) r_enable <= reg_wdata[SRC_NUM:1];
      if (reg_wr && (reg_addr == 6'h22)) r_thresh <= reg_wdata[PRIO_W-1:0];
      r_pending <= w_pend_next;
      r_best_id <= w_best_id;
      r_irq     <= (w_best_id != '0);
      if (w_rd) r_rdata <= w_rdata;
    end
  end

endmodule

// File: tb/tb_plic_gateway_arbiter.sv
// Bench for plic_gateway_arbiter: directed scenarios plus a random run against a
// transaction-level model of pending/claimed sources and the register map.
module tb_plic_gateway_arbiter;

  localparam int N = 8;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic        reg_wr;
  logic        reg_rd;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq_out;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int unsigned m_prio [1:N];
  bit          m_pend [1:N];
  bit          m_clm  [1:N];
  bit [N:1]    m_en;
  int unsigned m_thr;
  int unsigned m_best;
  bit          m_irq;
  logic [31:0] m_rdata;

  plic_gateway_arbiter #(.SRC_NUM(8), .PRIO_W(3)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq_out(irq_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    for (int id = 1; id <= N; id++) begin
      m_prio[id] = 0; m_pend[id] = 0; m_clm[id] = 0;
    end
    m_en = '0; m_thr = 0; m_best = 0; m_irq = 0; m_rdata = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] a);
    logic [31:0] v;
    v = '0;
    if (a >= 6'd1 && a <= 6'(N)) v = m_prio[int'(a)];
    else if (a == 6'h20) begin
      for (int id = 1; id <= N; id++) v[id] = m_pend[id];
    end
    else if (a == 6'h21) v = {23'd0, m_en, 1'b0};
    else if (a == 6'h22) v = m_thr;
    else if (a == 6'h23) v = m_best;
    return v;
  endfunction

  // One clock: drive inputs, advance the model by one edge, sample 1ns after the edge.
  task automatic tick(input bit wr, input bit rd, input logic [5:0] a,
                      input logic [31:0] d, input logic [7:0] src);
    int unsigned claim_id, win, win_score, score;
    logic [31:0] rd_n;
    reg_wr = wr; reg_rd = rd; reg_addr = a; reg_wdata = d; irq_src = src;
    claim_id = 0;
    rd_n = m_rdata;
    if (rd && !wr) begin
      rd_n = model_read(a);
      if (a == 6'h23) claim_id = m_best;
    end
    win = 0; win_score = 0;
    for (int id = 1; id <= N; id++) begin
      if (m_pend[id] && m_en[id] && m_prio[id] > m_thr && id != int'(claim_id)) begin
        score = m_prio[id] * 64 + (63 - id);
        if (score > win_score) begin win_score = score; win = id; end
      end
    end
    for (int id = 1; id <= N; id++) begin
      if (id == int'(claim_id)) begin
        m_pend[id] = 0; m_clm[id] = 1;
      end else if (m_clm[id]) begin
        m_pend[id] = 0;
        if (wr && a == 6'h23 && d == 32'(id)) m_clm[id] = 0;
      end else if (src[id-1]) begin
        m_pend[id] = 1;
      end
    end
    if (wr) begin
      if (a >= 6'd1 && a <= 6'(N)) m_prio[int'(a)] = d[2:0];
      if (a == 6'h21) m_en = d[N:1];
      if (a == 6'h22) m_thr = d[2:0];
    end
    m_best = win; m_irq = (win != 0); m_rdata = rd_n;
    @(posedge clk);
    #1;
    reg_wr = 1'b0; reg_rd = 1'b0;
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    irq_src = '0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_src = '0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_chk++; if (reg_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %0h want 0", reg_rdata); end
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_out); end
    tick(0, 1, 6'h20, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %0h want 0", reg_rdata); end
  endtask

  task automatic test_single_source();
    do_reset();
    tick(1, 0, 6'd3, 2, 8'h00);
    tick(1, 0, 6'h21, 32'h08, 8'h00);
    tick(1, 0, 6'h22, 0, 8'h00);
    tick(0, 0, 6'h00, 0, 8'h04);
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL t1_irq_edge1: got %b want 0", irq_out); end
    tick(0, 0, 6'h00, 0, 8'h00);
    n_chk++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL t1_irq_edge2: got %b want 1", irq_out); end
    tick(0, 1, 6'h20, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'h08) begin n_fail++; $display("FAIL t1_pending: got %0h want 08", reg_rdata); end
    tick(0, 1, 6'h23, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'd3) begin n_fail++; $display("FAIL t1_claim: got %0d want 3", reg_rdata); end
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL t1_irq_after_claim: got %b want 0", irq_out); end
    tick(0, 1, 6'h20, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'd0) begin n_fail++; $display("FAIL t1_pending_cleared: got %0h want 0", reg_rdata); end
  endtask

  task automatic test_priority_order();
    int exp_ids [3] = '{4, 2, 5};
    do_reset();
    tick(1, 0, 6'd2, 4, 8'h00);
    tick(1, 0, 6'd5, 4, 8'h00);
    tick(1, 0, 6'd4, 6, 8'h00);
    tick(1, 0, 6'h21, 32'h34, 8'h00);
    tick(0, 0, 6'h00, 0, 8'h1A);
    tick(0, 0, 6'h00, 0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 6'h23, 0, 8'h00);
      n_chk++; if (reg_rdata !== 32'(exp_ids[k])) begin n_fail++; $display("FAIL t2_claim%0d: got %0d want %0d", k, reg_rdata, exp_ids[k]); end
      tick(1, 0, 6'h23, 32'(exp_ids[k]), 8'h00);
    end
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL t2_irq_drained: got %b want 0", irq_out); end
  endtask

  task automatic test_threshold();
    do_reset();
    tick(1, 0, 6'h22, 4, 8'h00);
    tick(1, 0, 6'd1, 4, 8'h00);
    tick(1, 0, 6'd6, 5, 8'h00);
    tick(1, 0, 6'h21, 32'h42, 8'h00);
    tick(0, 0, 6'h00, 0, 8'h21);
    tick(0, 0, 6'h00, 0, 8'h00);
    n_chk++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL t3_irq: got %b want 1", irq_out); end
    tick(0, 1, 6'h23, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'd6) begin n_fail++; $display("FAIL t3_claim6: got %0d want 6", reg_rdata); end
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL t3_irq_after: got %b want 0", irq_out); end
    tick(0, 1, 6'h23, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'd0) begin n_fail++; $display("FAIL t3_claim_none: got %0d want 0", reg_rdata); end
    tick(0, 1, 6'h20, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'h02) begin n_fail++; $display("FAIL t3_pending1: got %0h want 02", reg_rdata); end
  endtask

  task automatic test_claimed_hold();
    do_reset();
    tick(1, 0, 6'd2, 3, 8'h00);
    tick(1, 0, 6'h21, 32'h04, 8'h00);
    tick(0, 0, 6'h00, 0, 8'h02);
    tick(0, 0, 6'h00, 0, 8'h02);
    tick(0, 1, 6'h23, 0, 8'h02);
    n_chk++; if (reg_rdata !== 32'd2) begin n_fail++; $display("FAIL t4_claim: got %0d want 2", reg_rdata); end
    repeat (3) tick(0, 0, 6'h00, 0, 8'h02);
    tick(0, 1, 6'h20, 0, 8'h02);
    n_chk++; if (reg_rdata !== 32'd0 || irq_out !== 1'b0) begin n_fail++; $display("FAIL t4_held: pending %0h irq %b want 0 0", reg_rdata, irq_out); end
    tick(1, 0, 6'h23, 7, 8'h02);
    tick(0, 0, 6'h00, 0, 8'h02);
    tick(0, 1, 6'h20, 0, 8'h02);
    n_chk++; if (reg_rdata !== 32'd0 || irq_out !== 1'b0) begin n_fail++; $display("FAIL t4_bad_complete: pending %0h irq %b want 0 0", reg_rdata, irq_out); end
    tick(1, 0, 6'h23, 2, 8'h02);
    tick(0, 0, 6'h00, 0, 8'h02);
    n_chk++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL t4_irq_edge1: got %b want 0", irq_out); end
    tick(0, 1, 6'h20, 0, 8'h02);
    n_chk++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL t4_irq_edge2: got %b want 1", irq_out); end
    n_chk++; if (reg_rdata !== 32'h04) begin n_fail++; $display("FAIL t4_repend: got %0h want 04", reg_rdata); end
    tick(0, 0, 6'h00, 0, 8'h00);
  endtask

  task automatic test_empty_claim_and_collision();
    do_reset();
    tick(1, 0, 6'h22, 5, 8'h00);
    tick(0, 1, 6'h22, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'd5) begin n_fail++; $display("FAIL t5_thr_read: got %0d want 5", reg_rdata); end
    tick(0, 1, 6'h23, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'd0) begin n_fail++; $display("FAIL t5_empty_claim: got %0d want 0", reg_rdata); end
    tick(0, 1, 6'h22, 0, 8'h00);
    tick(1, 1, 6'h21, 32'h1FE, 8'h00);
    n_chk++; if (reg_rdata !== 32'd5) begin n_fail++; $display("FAIL t5_wr_rd_hold: got %0h want 5", reg_rdata); end
    tick(0, 1, 6'h21, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'h1FE) begin n_fail++; $display("FAIL t5_enable: got %0h want 1fe", reg_rdata); end
    tick(0, 1, 6'h3F, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'd0) begin n_fail++; $display("FAIL t5_unmapped: got %0h want 0", reg_rdata); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1, 0, 6'd3, 1, 8'h00);
    tick(1, 0, 6'd1, 1, 8'h00);
    tick(1, 0, 6'h21, 32'h0A, 8'h00);
    tick(0, 0, 6'h00, 0, 8'h04);
    tick(0, 0, 6'h00, 0, 8'h00);
    tick(0, 1, 6'h23, 0, 8'h00);
    tick(0, 0, 6'h00, 0, 8'h01);
    tick(0, 0, 6'h00, 0, 8'h00);
    n_chk++; if (irq_out !== 1'b1 || reg_rdata !== 32'd3) begin n_fail++; $display("FAIL t6_pre: irq %b rdata %0d want 1 3", irq_out, reg_rdata); end
    #3 rst = 1'b1;
    #1;
    n_chk++; if (irq_out !== 1'b0 || reg_rdata !== 32'd0) begin n_fail++; $display("FAIL t6_async: irq %b rdata %0d want 0 0", irq_out, reg_rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    tick(0, 1, 6'h20, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'd0) begin n_fail++; $display("FAIL t6_pending: got %0h want 0", reg_rdata); end
    tick(0, 1, 6'h21, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'd0) begin n_fail++; $display("FAIL t6_enable: got %0h want 0", reg_rdata); end
    tick(1, 0, 6'd3, 1, 8'h00);
    tick(1, 0, 6'h21, 32'h08, 8'h00);
    tick(0, 0, 6'h00, 0, 8'h04);
    tick(0, 0, 6'h00, 0, 8'h00);
    tick(0, 1, 6'h23, 0, 8'h00);
    n_chk++; if (reg_rdata !== 32'd3) begin n_fail++; $display("FAIL t6_reclaim: got %0d want 3", reg_rdata); end
  endtask

  task automatic test_random();
    int r;
    bit wr, rd;
    logic [5:0] a;
    logic [31:0] d;
    logic [7:0] src;
    do_reset();
    src = '0;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      a = 6'h23;
      else if (r < 5) a = 6'($urandom_range(1, N));
      else if (r < 8) a = 6'($urandom_range(32, 34));
      else            a = 6'($urandom_range(0, 63));
      wr = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 1) == 0);
      d  = (a == 6'h23) ? 32'($urandom_range(0, 9)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) src = 8'($urandom);
      tick(wr, rd, a, d, src);
      n_chk++; if (reg_rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata@%0d: got %0h want %0h", c, reg_rdata, m_rdata); end
      n_chk++; if (irq_out !== m_irq) begin n_fail++; $display("FAIL rand_irq@%0d: got %b want %b", c, irq_out, m_irq); end
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_priority_order();
    test_threshold();
    test_claimed_hold();
    test_empty_claim_and_collision();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
